// File: rtl/char_pkg.sv
// Shared keycodes, movement state encoding and signed arithmetic types
// for the per-frame character mover.
package char_pkg;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } ch_state_t;

  typedef logic signed [4:0]  vel_t;
  typedef logic signed [10:0] cand_t;

endpackage

// File: rtl/character_physics_tile_probe.sv
// Combinational tile-map probe: ORs the solid bits of one fixed column (or row)
// across an inclusive span of rows (or columns).
module tile_probe #(
  parameter int ROWS      = 30,
  parameter int COLS      = 40,
  parameter bit COL_PROBE = 1'b1,
  parameter int IDX_W     = 6,
  parameter int SPAN_W    = 5
) (
  input  logic [ROWS-1:0][COLS-1:0] tile,
  input  logic [IDX_W-1:0]          idx,
  input  logic [SPAN_W-1:0]         lo,
  input  logic [SPAN_W-1:0]         hi,
  output logic                      hit,
  output logic [IDX_W-1:0]          hit_idx
);

  assign hit_idx = idx;

  if (COL_PROBE) begin : g_col
    always_comb begin
      hit = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (r >= int'(lo) && r <= int'(hi) && tile[r][idx]) hit = 1'b1;
      end
    end
  end else begin : g_row
    always_comb begin
      hit = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        if (c >= int'(lo) && c <= int'(hi) && tile[idx][c]) hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/character_physics.sv
// Per-frame character mover with gravity/jump state, border clamping and
// per-axis tile collision (horizontal resolved before vertical).
module character_physics
  import char_pkg::*;
#(
  parameter int CH_W       = 23,
  parameter int CH_H       = 30,
  parameter int X_START    = 80,
  parameter int Y_START    = 64,
  parameter int X_STEP     = 2,
  parameter int JUMP_V     = 6,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8,
  parameter int TILE_SHIFT = 4,
  parameter int ROWS       = 30,
  parameter int COLS       = 40,
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480,
  parameter int BORDER     = 16
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic [ROWS-1:0][COLS-1:0] tile,
  output logic [9:0]                chX,
  output logic [9:0]                chY,
  output logic [9:0]                chW,
  output logic [9:0]                chH,
  output logic [1:0]                state,
  output logic                      on_ground
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int XMIN = BORDER;
  localparam int XMAX = SCR_W - BORDER - CH_W;
  localparam int YMIN = BORDER;
  localparam int YMAX = SCR_H - BORDER - CH_H;

  if (JUMP_V > 15 || MAX_FALL > 15) begin : g_bad_vel
    $error("character_physics: JUMP_V and MAX_FALL must be <= 15");
  end

  function automatic logic [9:0] clamp(input cand_t v, input int lo, input int hi);
    if (v < cand_t'(lo)) return 10'(lo);
    if (v > cand_t'(hi)) return 10'(hi);
    return 10'(v);
  endfunction

  logic [9:0] x, y;
  vel_t       vy;
  ch_state_t  st;

  // Horizontal: step, clamp, then snap flush against a wall column.
  cand_t      dx, cand_x;
  logic       dx_pos, dx_neg;
  logic [9:0] cx, edge_x, x_next;
  logic [CW-1:0] col_idx, col_hit_idx;
  logic [RW-1:0] h_row_lo, h_row_hi;
  logic          col_hit;

  always_comb begin
    dx = '0;
    if (keycode == KEY_A)      dx = -cand_t'(X_STEP);
    else if (keycode == KEY_D) dx = cand_t'(X_STEP);
  end

  assign dx_neg   = dx[10];
  assign dx_pos   = !dx[10] && (dx != '0);
  assign cand_x   = cand_t'({1'b0, x}) + dx;
  assign cx       = clamp(cand_x, XMIN, XMAX);
  assign edge_x   = dx_pos ? cx + 10'(CH_W - 1) : cx;
  assign col_idx  = CW'(edge_x >> TILE_SHIFT);
  assign h_row_lo = RW'(y >> TILE_SHIFT);
  assign h_row_hi = RW'((y + 10'(CH_H - 1)) >> TILE_SHIFT);

  tile_probe #(
    .ROWS(ROWS), .COLS(COLS), .COL_PROBE(1'b1), .IDX_W(CW), .SPAN_W(RW)
  ) u_col_probe (
    .tile(tile), .idx(col_idx), .lo(h_row_lo), .hi(h_row_hi),
    .hit(col_hit), .hit_idx(col_hit_idx)
  );

  always_comb begin
    x_next = cx;
    if (dx_pos && col_hit)      x_next = (10'(col_hit_idx) << TILE_SHIFT) - 10'(CH_W);
    else if (dx_neg && col_hit) x_next = (10'(col_hit_idx) + 10'd1) << TILE_SHIFT;
  end

  // Vertical: velocity update, then a single row probe at the leading edge.
  logic       key_w, support_chk, vy_pos, vy_neg, row_hit;
  cand_t      vy_sum, vy_pre, cand_y, vy_next;
  logic [9:0] cy, row_px, y_next;
  logic [RW-1:0] row_idx, row_hit_idx;
  logic [CW-1:0] v_col_lo, v_col_hi;
  ch_state_t     st_next;

  assign key_w       = (keycode == KEY_W);
  assign support_chk = (st == GROUND) && !key_w;
  assign vy_sum      = cand_t'(vy) + cand_t'(GRAVITY);

  always_comb begin
    vy_pre = vy_sum;
    if (st == GROUND)                       vy_pre = key_w ? -cand_t'(JUMP_V) : cand_t'(GRAVITY);
    else if (vy_sum > cand_t'(MAX_FALL))    vy_pre = cand_t'(MAX_FALL);
  end

  assign vy_neg = vy_pre[10];
  assign vy_pos = !vy_pre[10] && (vy_pre != '0);
  assign cand_y = cand_t'({1'b0, y}) + vy_pre;
  assign cy     = clamp(cand_y, YMIN, YMAX);

  // On the ground the probe looks at the row just below the feet; with a
  // one-pixel gravity step that row is also the landing row of the first
  // falling frame, so one probe covers both.
  always_comb begin
    row_px = cy;
    if (support_chk) row_px = y + 10'(CH_H);
    else if (vy_pos) row_px = cy + 10'(CH_H - 1);
  end

  assign row_idx  = RW'(row_px >> TILE_SHIFT);
  assign v_col_lo = CW'(x_next >> TILE_SHIFT);
  assign v_col_hi = CW'((x_next + 10'(CH_W - 1)) >> TILE_SHIFT);

  tile_probe #(
    .ROWS(ROWS), .COLS(COLS), .COL_PROBE(1'b0), .IDX_W(RW), .SPAN_W(CW)
  ) u_row_probe (
    .tile(tile), .idx(row_idx), .lo(v_col_lo), .hi(v_col_hi),
    .hit(row_hit), .hit_idx(row_hit_idx)
  );

  always_comb begin
    y_next  = cy;
    vy_next = vy_pre;
    st_next = vy_neg ? RISE : FALL;
    if (support_chk && row_hit) begin
      y_next  = y;
      vy_next = '0;
      st_next = GROUND;
    end else if (vy_pos) begin
      if (row_hit) begin
        y_next  = (10'(row_hit_idx) << TILE_SHIFT) - 10'(CH_H);
        vy_next = '0;
        st_next = GROUND;
      end else if (cand_y >= cand_t'(YMAX)) begin
        vy_next = '0;
        st_next = GROUND;
      end
    end else if (vy_neg) begin
      if (row_hit) begin
        y_next  = (10'(row_hit_idx) + 10'd1) << TILE_SHIFT;
        vy_next = '0;
        st_next = FALL;
      end else if (cand_y <= cand_t'(YMIN)) begin
        vy_next = '0;
        st_next = FALL;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x  <= 10'(X_START);
      y  <= 10'(Y_START);
      vy <= '0;
      st <= FALL;
    end else begin
      x  <= x_next;
      y  <= y_next;
      vy <= vel_t'(vy_next);
      st <= st_next;
    end
  end

  assign chX       = x;
  assign chY       = y;
  assign chW       = 10'(CH_W);
  assign chH       = 10'(CH_H);
  assign state     = st;
  assign on_ground = (st == GROUND);

endmodule

// File: tb/tb_character_physics.sv
// Directed bench for character_physics: reset, free fall, jump arc, wall snap,
// border clamp and head bump, with hand-computed expected positions.
module tb_character_physics;

  logic               frame_clk;
  logic               Reset;
  logic [7:0]         keycode;
  logic [29:0][39:0]  tile;
  logic [9:0]         chX, chY, chW, chH;
  logic [1:0]         state;
  logic               on_ground;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] key;
    int         ex;
    int         ey;
    int         est;
  } vec_t;

  vec_t tab[$];

  character_physics dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .keycode  (keycode),
    .tile     (tile),
    .chX      (chX),
    .chY      (chY),
    .chW      (chW),
    .chH      (chH),
    .state    (state),
    .on_ground(on_ground)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic frame(input logic [7:0] k);
    keycode = k;
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    int wall_exp[6];
    Reset   = 1'b1;
    keycode = 8'h00;
    tile    = '0;
    repeat (2) @(posedge frame_clk);
    #1;
    check("reset.chX", chX, 80);
    check("reset.chY", chY, 64);
    check("reset.state", state, 2);
    check("reset.on_ground", on_ground, 0);
    check("chW", chW, 23);
    check("chH", chH, 30);
    Reset = 1'b0;

    // Empty map: fall onto the bottom border clamp.
    repeat (60) frame(8'h00);
    check("floor_clamp.chY", chY, 434);
    check("floor_clamp.state", state, 0);
    check("floor_clamp.on_ground", on_ground, 1);
    check("floor_clamp.chX", chX, 80);

    // Asynchronous reset between frame edges.
    #3 Reset = 1'b1;
    #1;
    check("async_rst.chX", chX, 80);
    check("async_rst.chY", chY, 64);
    check("async_rst.state", state, 2);
    check("async_rst.on_ground", on_ground, 0);
    @(posedge frame_clk);
    #1 Reset = 1'b0;

    // Floor at tile row 10: fall, land, hold, jump arc (W while airborne ignored).
    tile[10] = '1;
    tab.push_back('{8'h00, 80,  65, 2});
    tab.push_back('{8'h00, 80,  67, 2});
    tab.push_back('{8'h00, 80,  70, 2});
    tab.push_back('{8'h00, 80,  74, 2});
    tab.push_back('{8'h00, 80,  79, 2});
    tab.push_back('{8'h00, 80,  85, 2});
    tab.push_back('{8'h00, 80,  92, 2});
    tab.push_back('{8'h00, 80, 100, 2});
    tab.push_back('{8'h00, 80, 108, 2});
    tab.push_back('{8'h00, 80, 116, 2});
    tab.push_back('{8'h00, 80, 124, 2});
    tab.push_back('{8'h00, 80, 130, 0});
    tab.push_back('{8'h00, 80, 130, 0});
    tab.push_back('{8'h1A, 80, 124, 1});
    tab.push_back('{8'h1A, 80, 119, 1});
    tab.push_back('{8'h00, 80, 115, 1});
    tab.push_back('{8'h00, 80, 112, 1});
    tab.push_back('{8'h00, 80, 110, 1});
    tab.push_back('{8'h00, 80, 109, 1});
    tab.push_back('{8'h00, 80, 109, 2});
    tab.push_back('{8'h1A, 80, 110, 2});
    tab.push_back('{8'h00, 80, 112, 2});
    tab.push_back('{8'h00, 80, 115, 2});
    tab.push_back('{8'h00, 80, 119, 2});
    tab.push_back('{8'h00, 80, 124, 2});
    tab.push_back('{8'h00, 80, 130, 2});
    tab.push_back('{8'h00, 80, 130, 0});
    for (int i = 0; i < tab.size(); i++) begin
      frame(tab[i].key);
      check($sformatf("vec[%0d].chX", i), chX, tab[i].ex);
      check($sformatf("vec[%0d].chY", i), chY, tab[i].ey);
      check($sformatf("vec[%0d].state", i), state, tab[i].est);
    end

    // Wall at column 10, rows 4-9: walk right and snap flush at x=137.
    for (int r = 4; r <= 9; r++) tile[r][10] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      frame(8'h07);
      check($sformatf("walk_r[%0d].chX", k), chX, 80 + 2 * k);
    end
    check("walk_r.chY", chY, 130);
    wall_exp = '{132, 134, 136, 137, 137, 137};
    for (int i = 0; i < 6; i++) begin
      frame(8'h07);
      check($sformatf("wall[%0d].chX", i), chX, wall_exp[i]);
    end
    check("wall.state", state, 0);

    // Walk left to x=17, then the left border clamp holds at 16.
    for (int k = 1; k <= 60; k++) begin
      frame(8'h04);
      check($sformatf("walk_l[%0d].chX", k), chX, 137 - 2 * k);
    end
    frame(8'h04);
    check("left_clamp0.chX", chX, 16);
    frame(8'h04);
    check("left_clamp1.chX", chX, 16);
    check("left_clamp.chY", chY, 130);

    // Ceiling at row 7: jump bumps the head at 128, then lands back at 130.
    tile[7] = '1;
    frame(8'h1A);
    check("bump.chY", chY, 128);
    check("bump.state", state, 2);
    frame(8'h00);
    check("bump_fall.chY", chY, 129);
    check("bump_fall.state", state, 2);
    frame(8'h00);
    check("bump_land.chY", chY, 130);
    check("bump_land.state", state, 0);
    check("bump_land.on_ground", on_ground, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/character_physics.md
Name: character_physics

Overview:
- Parametrised successor to the tile-map character mover, with sprite size, step, tile geometry and screen border set by parameters.
- Adds a gravity/jump state machine, signed vertical velocity, and per-axis tile collision with snap-flush resolution.
- Updates once per frame on frame_clk and consumes the same keycode and tile-map buses.
- Feeds chX/chY/chW/chH to the sprite renderer, plus a state output for animation selection.

Parameters:
- CH_W, 23: sprite width in pixels.
- CH_H, 30: sprite height in pixels.
- X_START, 80: reset X (upper-left corner).
- Y_START, 64: reset Y (upper-left corner).
- X_STEP, 2: horizontal pixels per frame while A or D is held.
- JUMP_V, 6: initial upward speed on jump.
- GRAVITY, 1: downward speed added per airborne frame.
- MAX_FALL, 8: terminal downward speed.
- TILE_SHIFT, 4: log2 of tile size (16 px).
- ROWS, 30: tile-map rows.
- COLS, 40: tile-map columns.
- SCR_W, 640: screen width.
- SCR_H, 480: screen height.
- BORDER, 16: wall thickness at each screen edge.

Ports:
- frame_clk  in  1  frame-rate clock (one update per rising edge).
- Reset  in  1  asynchronous active-high reset.
- keycode  in  8  04=A left, 07=D right, 1A=W jump; any other value = idle.
- tile  in  [ROWS-1:0][COLS-1:0]  1 = solid tile.
- chX  out  10  registered sprite X.
- chY  out  10  registered sprite Y.
- chW  out  10  constant CH_W.
- chH  out  10  constant CH_H.
- state  out  2  0=GROUND, 1=RISE, 2=FALL.
- on_ground  out  1  high when state==GROUND.

Behaviour:
- Reset (async): chX=X_START, chY=Y_START, vy=0, state=FALL, on_ground=0.
- All updates are single-cycle: outputs reflect the frame computed on the preceding edge. No pipeline.
- Occupied rectangle is x..x+CH_W-1 by y..y+CH_H-1 (inclusive).
- Tile index = pixel >> TILE_SHIFT.
- Candidates are computed as 11-bit signed values.
- Each candidate is clamped to [BORDER, SCR_W-BORDER-CH_W] in X and [BORDER, SCR_H-BORDER-CH_H] in Y before any tile lookup, so indices never go out of range.
- Horizontal resolution, first:
  - dx = -X_STEP for A, +X_STEP for D, else 0.
  - cx = clamp(x+dx).
  - If dx>0, probe column (cx+CH_W-1)>>TILE_SHIFT over rows y>>s .. (y+CH_H-1)>>s. If any tile is solid, x_next=(col<<s)-CH_W (flush left of the wall).
  - If dx<0, probe column cx>>s. If solid, x_next=(col+1)<<s.
  - Otherwise x_next=cx.
- Vertical resolution, second, using x_next for the columns:
  - GROUND: W pressed -> vy_next=-JUMP_V, go RISE. Otherwise probe the row (y+CH_H)>>s directly below; if no tile there, vy_next=GRAVITY and go FALL; else vy_next=0.
  - RISE/FALL: vy_next=min(vy+GRAVITY, MAX_FALL). State = RISE if vy_next<0, else FALL.
  - Candidate cy=clamp(y+vy_next).
  - If vy_next>0, probe row (cy+CH_H-1)>>s. If solid: y_next=(row<<s)-CH_H, vy=0, go GROUND.
  - If vy_next<0, probe row cy>>s. If solid: y_next=(row+1)<<s, vy=0, go FALL (head bump).
  - Hitting the bottom Y clamp counts as landing (GROUND). Hitting the top clamp counts as a head bump (FALL).
- W while RISE/FALL is ignored (no double jump). W held continuously re-jumps on the first GROUND frame.
- A or D may be pressed while airborne; horizontal and vertical motion are independent.
- Horizontal is resolved before vertical each frame, so corner contacts resolve the wall before the floor.
- Reset mid-jump returns immediately to the reset values; there is no residual velocity.
- vy is a 5-bit signed register. The parameter check requires JUMP_V and MAX_FALL to be ≤ 15.

Decomposition:
- Package char_pkg:
  - keycode constants KEY_A/KEY_D/KEY_W.
  - typedef enum logic [1:0] {GROUND, RISE, FALL} ch_state_t.
  - Signed velocity typedef.
- Sub-module tile_probe: combinational.
  - Given a fixed row or column index and a span range, returns the OR of the solid bits and the hit index.
  - Instantiated twice: one for the column probe, one for the row probe.

Test Plan:
- Reset asserted mid-frame, empty map -> chX=80, chY=64, state=FALL, vy=0 immediately (async).
- Floor at tile row 10 (y=160), start y=64, keycode 00 -> y falls with vy 1,2,..8; lands at chY=130 exactly, state=GROUND, vy=0.
- From GROUND at y=130, one frame of keycode 1A -> chY=124, state=RISE. Then 119, 115, 112, 110, 109, 109, then descending (FALL), landing back at 130 in GROUND.
- Wall at column 10 rows 4-9, chX=130, y=130, D held -> chX 132, 134, 136, then snaps to 137 and stays 137 on every following frame.
- chX=17, A held, no tiles -> chX=16, then stays 16 (border clamp).
- Ceiling at row 7 (y=112..127), on floor at y=130, W -> candidate 124 overlaps row 7 -> chY=128, state=FALL, then lands back to 130.
